sdpram_row_reader: RTL and testbench
====================================

// Module: sdpram_row_reader
// PURPOSE
// Read-side client for one port of the 32x256 sdpram in the matrix engine.
// On start, fetches num_rows consecutive rows beginning at base_addr, with
// wrap modulo 32, and streams them out on a valid/ready interface with
// row_last on the final row. Absorbs the RAM's 1-cycle synchronous read
// latency with a 2-entry output FIFO, sustaining 1 row/cycle under full ready.
// PARAMETERS
// DATA_W  256  row width; must match the sdpram data width
// ADDR_W  5    RAM address width; depth = 2**ADDR_W = 32 rows
// PORTS
// clk        in   1         clock; all state updates on its rising edge
// rst_n      in   1         asynchronous active-low reset
// start      in   1         request a transfer; sampled only in IDLE
// base_addr  in   ADDR_W    first row address; captured when start accepted
// num_rows   in   ADDR_W+1  row count 0..32; captured when start accepted
// ram_addr   out  ADDR_W    drives the sdpram addr port
// ram_wen    out  1         drives the sdpram wen port; constant 0
// ram_q      in   DATA_W    sdpram q; valid the cycle after addr is sampled
// row_data   out  DATA_W    output row
// row_valid  out  1         row_data/row_last valid
// row_ready  in   1         downstream accepts; handshake = valid & ready
// row_last   out  1         marks the final row of the transfer
// busy       out  1         transfer in progress
// done       out  1         1-cycle pulse after the final row handshake
// BEHAVIOUR
// - Reset values: ram_addr=0, ram_wen=0, row_data=0, row_valid=0,
//   row_last=0, busy=0, done=0, FIFO empty, in-flight flag clear, FSM=IDLE.
// - FSM states:
//   - IDLE: start=1 captures base/num and goes to READ (num=0: goes to DONE).
//   - READ: all num reads issued goes to DRAIN.
//   - DRAIN: last row handshaken goes to DONE.
//   - DONE: done=1 for 1 cycle, then IDLE.
// - busy=1 in READ and DRAIN; 0 in IDLE and DONE. start is ignored while
//   busy=1; no queueing. start is ignored in DONE; accepted from the next IDLE.
// - Issue rule, in READ only: issue when cnt + inflight - pop < 2.
//   - cnt = FIFO entries; inflight = read issued last cycle; pop = handshake.
//   - On issue: ram_addr = base + i (mod 32), i++, inflight set next cycle.
//   - When not issuing, ram_addr holds its value.
// - Data path: the cycle after an issue, ram_q is written into the FIFO.
//   - FIFO write and pop may occur in the same cycle.
//   - The FIFO never overflows; overflow is an assertion failure.
// - Latency: start high in cycle 0 -> READ in cycle 1 with addr=base ->
//   ram_q in cycle 2 -> row_valid=1 in cycle 3.
// - Throughput: with row_ready held 1, one row per cycle, no bubbles.
// - Output: row_valid = FIFO not empty; row_data/row_last = FIFO head.
//   - row_data and row_last stay stable while row_valid & !row_ready.
// - row_last is tagged at issue time on read index num-1.
//   - num=32 reads every row exactly once.
// - Wrap: base=30, num=4 reads addrs 30, 31, 0, 1.
// - num_rows=0: no reads, no row_valid; done pulses 1 cycle after acceptance.
// - num_rows>32 is illegal; assert in simulation.
// - Mid-transfer reset: all state clears immediately, outputs return to reset
//   values, any in-flight ram_q is discarded, and no done is produced.
// - ram_wen is never 1; the write path is owned by the other port.
// TESTING (bench: sdpram + this block on port A; bench preloads via port B)
// 1 Preload row k = 1000+k. start, base=1, num=2, ready=1 -> rows 1001,
//   1002; row_valid first in cycle 3; last=1 on 1002; done 1 cycle later.
// 2 base=0, num=32, ready=1 -> 32 rows on 32 consecutive cycles;
//   last only on row 1031.
// 3 base=30, num=4 -> ram_addr 30, 31, 0, 1; data 1030, 1031, 1000, 1001.
// 4 num=8, ready toggling 1,0,0,1,... -> all 8 rows in order, none
//   lost/duplicated, data stable while stalled, FIFO count never exceeds 2.
// 5 num=0 -> no row_valid; done pulse next cycle. Also, start pulsed while
//   busy -> ignored, and the transfer count is unchanged.
// 6 Drop rst_n during row 3 of num=8 -> outputs 0 and IDLE immediately.
//   A new start with num=2 after release -> 2 correct rows.

Source files
------------

// File: rtl/sdpram_row_reader.sv
// -----------------------------------------------------------------------------
// sdpram_row_reader
// Read-side client for one port of the 32x256 simple dual-port RAM used by the
// matrix engine. A start request captures a base row and a row count, the
// block then reads that many consecutive rows (wrapping modulo the RAM depth)
// and streams them out over a valid/ready interface, tagging the final row.
// The RAM's one-cycle synchronous read latency is absorbed by a 2-entry output
// FIFO, so a transfer runs at one row per cycle while row_ready stays high.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      transfer request, sampled only in IDLE
//   base_addr  first row address, captured on accepted start
//   num_rows   row count 0..2**ADDR_W, captured on accepted start
//   ram_addr   RAM read address (registered)
//   ram_wen    RAM write enable, tied low
//   ram_q      RAM read data, valid the cycle after ram_addr is sampled
//   row_data   FIFO head data
//   row_valid  FIFO not empty
//   row_ready  downstream accept
//   row_last   FIFO head is the final row of the transfer
//   busy       transfer in progress (READ or DRAIN)
//   done       one-cycle pulse after the final row handshake
// -----------------------------------------------------------------------------

// Simulation checks on internal invariants of the reader.
module sdpram_row_reader_chk #(
  parameter int ADDR_W = 5
) (
  input logic              clk_i,
  input logic              rst_n_i,
  input logic              start_acc_i,
  input logic [ADDR_W:0]   num_rows_i,
  input logic [1:0]        cnt_i,
  input logic              push_i,
  input logic              pop_i
);
  localparam logic [ADDR_W:0] MAX_ROWS = (ADDR_W+1)'(2**ADDR_W);

  // A transfer longer than the RAM depth is not a legal request.
  a_num_rows_range: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    start_acc_i |-> (num_rows_i <= MAX_ROWS));

  // The issue rule must keep the FIFO from ever taking a third entry.
  a_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !((cnt_i == 2'd2) && push_i && !pop_i));
endmodule

module sdpram_row_reader #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_rows,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] row_data,
  output logic              row_valid,
  input  logic              row_ready,
  output logic              row_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   num_q, num_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] fifo_data_q [2];
  logic [1:0]        fifo_last_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q, cnt_d;

  logic              start_acc_s, issue_s, last_issue_s, push_s, pop_s;
  logic [2:0]        occ_s, lim_s;

  assign start_acc_s  = (state_q == S_IDLE) && start;
  assign last_issue_s = (idx_q == (num_q - CNT_ONE));
  // Occupancy counts the in-flight read as already owning a FIFO slot; a slot
  // freed by this cycle's pop can be reused immediately.
  assign occ_s   = {1'b0, cnt_q} + {2'b00, infl_q};
  assign lim_s   = 3'd2 + {2'b00, pop_s};
  assign issue_s = (state_q == S_READ) && (idx_q != num_q) && (occ_s < lim_s);

  assign push_s    = infl_q;
  assign row_valid = (cnt_q != 2'd0);
  assign pop_s     = row_valid && row_ready;
  assign row_data  = fifo_data_q[rd_ptr_q];
  assign row_last  = row_valid && fifo_last_q[rd_ptr_q];

  assign ram_addr = addr_q;
  assign ram_wen  = 1'b0;
  assign busy     = busy_q;
  assign done     = done_q;

  // State register plus registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (num_rows == CNT_ZERO) ? S_DONE : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (issue_s && last_issue_s) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        if (pop_s && row_last) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the next state so they register in step with it.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_READ:  busy_d = 1'b1;
      S_DRAIN: busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Read issue: ram_addr always holds the address of the next read, so the
  // captured base is on the bus in the first READ cycle.
  always_comb begin
    num_d       = num_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    infl_d      = 1'b0;
    infl_last_d = 1'b0;
    if (start_acc_s) begin
      num_d  = num_rows;
      idx_d  = CNT_ZERO;
      addr_d = base_addr;
    end else if (issue_s) begin
      idx_d       = idx_q + CNT_ONE;
      infl_d      = 1'b1;
      infl_last_d = last_issue_s;
      // Stop advancing after the final read so the bus rests on the last row.
      if (!last_issue_s) begin
        addr_d = addr_q + ADDR_ONE;
      end else begin
        addr_d = addr_q;
      end
    end else begin
      addr_d = addr_q;
    end
  end

  // Issue-side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q       <= CNT_ZERO;
      idx_q       <= CNT_ZERO;
      addr_q      <= {ADDR_W{1'b0}};
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      num_q       <= num_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
    end
  end

  // FIFO occupancy update; push and pop may coincide.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage and pointers; the row_last tag travels with its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        fifo_data_q[k] <= {DATA_W{1'b0}};
      end
      fifo_last_q <= 2'b00;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_data_q[wr_ptr_q] <= ram_q;
        fifo_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  sdpram_row_reader_chk #(.ADDR_W(ADDR_W)) u_chk (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_acc_i (start_acc_s),
    .num_rows_i  (num_rows),
    .cnt_i       (cnt_q),
    .push_i      (push_s),
    .pop_i       (pop_s)
  );
endmodule

// File: tb/tb_sdpram_row_reader.sv
// -----------------------------------------------------------------------------
// tb_sdpram_row_reader
// Bench for sdpram_row_reader: a behavioural synchronous-read RAM sits on the
// read port, expected rows are derived from the RAM contents with modulo
// arithmetic and checked in order at every handshake.
// -----------------------------------------------------------------------------
module tb_sdpram_row_reader;
  localparam int DATA_W = 256;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_rows;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wen;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] row_data;
  logic              row_valid;
  logic              row_ready;
  logic              row_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem [0:31];
  int                addr_log [0:511];
  int                vectors = 0;
  int                miscompares = 0;

  always #5 clk = ~clk;

  // Behavioural RAM read port: data appears the cycle after the address.
  always @(posedge clk) ram_q <= mem[ram_addr];

  sdpram_row_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .ram_addr  (ram_addr),
    .ram_wen   (ram_wen),
    .ram_q     (ram_q),
    .row_data  (row_data),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_last  (row_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer. rmode: 0 ready held high, 1 ready 1,0,0 repeating, 2 random.
  // poke: cycle in which a stray start is pulsed while busy (-1 for none).
  task automatic xfer(input int b, input int n, input int rmode, input int poke,
                      output int first_v, output int first_hs, output int last_hs,
                      output int done_c);
    logic [DATA_W-1:0] eq[$];
    logic              lq[$];
    logic              stall, sl;
    logic [DATA_W-1:0] sd;
    int                cyc, nhs;
    logic              fin;
    logic [ADDR_W-1:0] bb;
    logic [ADDR_W:0]   nn;
    for (int k = 0; k < n; k++) begin
      eq.push_back(mem[(b + k) % 32]);
      lq.push_back(k == n - 1);
    end
    first_v = -1; first_hs = -1; last_hs = -1; done_c = -1;
    nhs = 0; cyc = 0; stall = 1'b0; sl = 1'b0; sd = '0; fin = 1'b0;
    bb = b[ADDR_W-1:0];
    nn = n[ADDR_W:0];
    @(posedge clk); #1;
    start = 1'b1; base_addr = bb; num_rows = nn; row_ready = 1'b1;
    while (!fin && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      // Change the request inputs so a missing capture would show up.
      start     = (cyc == poke);
      base_addr = bb + 5'd3;
      num_rows  = 6'd3;
      case (rmode)
        0:       row_ready = 1'b1;
        1:       row_ready = ((cyc % 3) == 0);
        default: row_ready = ($urandom_range(0, 1) == 1);
      endcase
      addr_log[cyc] = int'(ram_addr);
      chk("ram_wen", ram_wen, 1'b0);
      if (cyc == 1) chk("busy_start", busy, (n != 0));
      if (stall) begin
        chk("stall_valid", row_valid, 1'b1);
        chk("stall_data", row_data, sd);
        chk("stall_last", row_last, sl);
      end
      if (row_valid && first_v < 0) first_v = cyc;
      if (row_valid && row_ready) begin
        if (eq.size() == 0) begin
          chk("extra_row", nhs + 1, n);
        end else begin
          chk("row_data", row_data, eq.pop_front());
          chk("row_last", row_last, lq.pop_front());
        end
        nhs++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      stall = row_valid && !row_ready;
      sd = row_data;
      sl = row_last;
      if (done) begin
        done_c = cyc;
        fin = 1'b1;
        chk("busy_in_done", busy, 1'b0);
      end
    end
    start = 1'b0;
    chk("done_seen", fin, 1'b1);
    chk("rows_left", eq.size(), 0);
    chk("row_count", nhs, n);
    @(posedge clk); #1;
    chk("done_pulse_width", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_valid", row_valid, 1'b0);
  endtask

  initial begin
    int fv, fh, lh, dc, hs;
    int rb, rn, rm, rp;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; row_ready = 1'b0;
    for (int k = 0; k < 32; k++) mem[k] = DATA_W'(1000 + k);
    #1;
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wen", ram_wen, 1'b0);
    chk("rst_row_data", row_data, 0);
    chk("rst_row_valid", row_valid, 1'b0);
    chk("rst_row_last", row_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    #22 rst_n = 1'b1;

    // Two rows from base 1: latency and done timing.
    xfer(1, 2, 0, -1, fv, fh, lh, dc);
    chk("t1_first_valid", fv, 3);
    chk("t1_last_hs", lh, 4);
    chk("t1_done_cycle", dc, lh + 1);

    // Full RAM sweep at full throughput.
    xfer(0, 32, 0, -1, fv, fh, lh, dc);
    chk("t2_first_valid", fv, 3);
    chk("t2_back_to_back", lh - fh, 31);
    chk("t2_done_cycle", dc, lh + 1);

    // Wrap past the top of the RAM.
    xfer(30, 4, 0, -1, fv, fh, lh, dc);
    for (int k = 0; k < 4; k++) chk("t3_ram_addr", addr_log[1 + k], (30 + k) % 32);

    // Backpressure with ready pattern 1,0,0.
    xfer(2, 8, 1, -1, fv, fh, lh, dc);
    chk("t4_first_valid", fv, 3);

    // Zero-length transfer, then a stray start while busy.
    xfer(9, 0, 0, -1, fv, fh, lh, dc);
    chk("t5_no_valid", fv, -1);
    chk("t5_done_cycle", dc, 1);
    xfer(3, 4, 0, 2, fv, fh, lh, dc);

    // Reset in the middle of a transfer.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 5'd0; num_rows = 6'd8; row_ready = 1'b1; hs = 0;
    for (int c = 0; c < 20 && hs < 2; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (row_valid && row_ready) hs++;
    end
    @(posedge clk); #1;
    chk("t6_progress", hs, 2);
    chk("t6_valid_before", row_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_row_valid", row_valid, 1'b0);
    chk("t6_row_data", row_data, 0);
    chk("t6_row_last", row_last, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ram_addr", ram_addr, 0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("t6_done_in_reset", done, 1'b0);
    end
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("t6_done_after_reset", done, 1'b0);
      chk("t6_valid_after_reset", row_valid, 1'b0);
    end
    xfer(5, 2, 0, -1, fv, fh, lh, dc);
    chk("t6_restart_first_valid", fv, 3);

    // Random contents, bases, lengths and backpressure.
    for (int k = 0; k < 32; k++) mem[k] = {8{$urandom()}};
    for (int t = 0; t < 8; t++) begin
      rb = int'($urandom_range(0, 31));
      rn = int'($urandom_range(1, 32));
      rm = (t == 0) ? 0 : 2;
      rp = int'($urandom_range(1, 6));
      xfer(rb, rn, rm, rp, fv, fh, lh, dc);
      chk("rnd_first_valid", fv, 3);
      chk("rnd_done_cycle", dc, lh + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
